// File: rtl/wb_arbiter.sv
// Writeback merge stage: ALU results (never stalled) and LSU results (buffered in a
// small FIFO) share one register-file write port. ALU always wins.
module wb_arbiter #(
  parameter int XLEN                = 32,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int LSU_FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [XLEN-1:0]                     alu_wb_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      alu_wb_rd_addr,
  input  logic                                alu_wb_rd_wr_en,
  input  logic [XLEN-1:0]                     alu_instr_tag,
  input  logic                                lsu_wb_valid,
  output logic                                lsu_wb_ready,
  input  logic [XLEN-1:0]                     lsu_wb_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]      lsu_wb_rd_addr,
  input  logic [XLEN-1:0]                     lsu_instr_tag,
  output logic                                rf_wr_en,
  output logic [REG_FILE_ADDR_WIDTH-1:0]      rf_wr_addr,
  output logic [XLEN-1:0]                     rf_wr_data,
  output logic [XLEN-1:0]                     retire_tag,
  output logic                                retire_src,
  output logic [$clog2(LSU_FIFO_DEPTH):0]     fifo_count,
  output logic [CNT_WIDTH-1:0]                retire_count
);

  localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LSU_FIFO_DEPTH);

  logic [XLEN-1:0]                data_mem [LSU_FIFO_DEPTH];
  logic [REG_FILE_ADDR_WIDTH-1:0] addr_mem [LSU_FIFO_DEPTH];
  logic [XLEN-1:0]                tag_mem  [LSU_FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic                           rf_wr_en_reg;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_wr_addr_reg;
  logic [XLEN-1:0]                rf_wr_data_reg;
  logic [XLEN-1:0]                retire_tag_reg;
  logic                           retire_src_reg;
  logic [CNT_WIDTH-1:0]           retire_count_reg;

  logic push;
  logic pop;

  // Ready depends only on the registered count, so a full FIFO refuses even when popping.
  assign lsu_wb_ready = ~rst & (count_reg < DEPTH_C);
  assign push         = lsu_wb_valid & lsu_wb_ready;
  assign pop          = ~alu_wb_rd_wr_en & (count_reg != '0);

  generate
    for (genvar gi = 0; gi < LSU_FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          data_mem[gi] <= lsu_wb_data;
          addr_mem[gi] <= lsu_wb_rd_addr;
          tag_mem[gi]  <= lsu_instr_tag;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output register: address/data/tag/src hold their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en_reg     <= 1'b0;
      rf_wr_addr_reg   <= '0;
      rf_wr_data_reg   <= '0;
      retire_tag_reg   <= '0;
      retire_src_reg   <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      retire_count_reg <= retire_count_reg + CNT_WIDTH'(rf_wr_en_reg);
      if (alu_wb_rd_wr_en) begin
        rf_wr_en_reg   <= 1'b1;
        rf_wr_addr_reg <= alu_wb_rd_addr;
        rf_wr_data_reg <= alu_wb_data;
        retire_tag_reg <= alu_instr_tag;
        retire_src_reg <= 1'b0;
      end else if (pop) begin
        rf_wr_en_reg   <= 1'b1;
        rf_wr_addr_reg <= addr_mem[rd_ptr_reg];
        rf_wr_data_reg <= data_mem[rd_ptr_reg];
        retire_tag_reg <= tag_mem[rd_ptr_reg];
        retire_src_reg <= 1'b1;
      end else begin
        rf_wr_en_reg   <= 1'b0;
      end
    end
  end

  assign rf_wr_en     = rf_wr_en_reg;
  assign rf_wr_addr   = rf_wr_addr_reg;
  assign rf_wr_data   = rf_wr_data_reg;
  assign retire_tag   = retire_tag_reg;
  assign retire_src   = retire_src_reg;
  assign fifo_count   = count_reg;
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] alu_wb_data;
  logic [AW-1:0]   alu_wb_rd_addr;
  logic            alu_wb_rd_wr_en;
  logic [XLEN-1:0] alu_instr_tag;
  logic            lsu_wb_valid;
  logic            lsu_wb_ready;
  logic [XLEN-1:0] lsu_wb_data;
  logic [AW-1:0]   lsu_wb_rd_addr;
  logic [XLEN-1:0] lsu_instr_tag;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [XLEN-1:0] retire_tag;
  logic            retire_src;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNTW-1:0] retire_count;

  always #5 clk = ~clk;

  wb_arbiter #(
    .XLEN(XLEN), .REG_FILE_ADDR_WIDTH(AW), .LSU_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_wb_data(alu_wb_data), .alu_wb_rd_addr(alu_wb_rd_addr),
    .alu_wb_rd_wr_en(alu_wb_rd_wr_en), .alu_instr_tag(alu_instr_tag),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_data(lsu_wb_data), .lsu_wb_rd_addr(lsu_wb_rd_addr),
    .lsu_instr_tag(lsu_instr_tag),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .retire_tag(retire_tag), .retire_src(retire_src),
    .fifo_count(fifo_count), .retire_count(retire_count)
  );

  typedef struct {
    logic [XLEN-1:0] data;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] tag;
  } entry_t;

  // Reference model: pending LSU results are a plain queue, outputs are what the
  // register-file port should show after each edge.
  entry_t          q[$];
  logic            m_en;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  logic [XLEN-1:0] m_tag;
  logic            m_src;
  int unsigned     m_writes;
  logic            last_accept;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_alu(input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                         input logic [XLEN-1:0] t);
    alu_wb_rd_wr_en = en;
    alu_wb_rd_addr  = a;
    alu_wb_data     = d;
    alu_instr_tag   = t;
  endtask

  task automatic set_lsu(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                         input logic [XLEN-1:0] t);
    lsu_wb_valid   = v;
    lsu_wb_rd_addr = a;
    lsu_wb_data    = d;
    lsu_instr_tag  = t;
  endtask

  // One clock: check ready, advance the model over the edge, compare all outputs.
  task automatic cycle();
    logic   pre_ready;
    entry_t e;
    #1;
    pre_ready = !rst && (q.size() < DEPTH);
    check("lsu_wb_ready", 64'(lsu_wb_ready), 64'(pre_ready));
    last_accept = lsu_wb_valid && pre_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_en = 0; m_addr = '0; m_data = '0; m_tag = '0; m_src = 0; m_writes = 0;
      last_accept = 0;
    end else begin
      if (m_en) m_writes++;
      if (alu_wb_rd_wr_en) begin
        m_en = 1; m_addr = alu_wb_rd_addr; m_data = alu_wb_data; m_tag = alu_instr_tag; m_src = 0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_en = 1; m_addr = e.addr; m_data = e.data; m_tag = e.tag; m_src = 1;
      end else begin
        m_en = 0;
      end
      if (last_accept) begin
        e.data = lsu_wb_data; e.addr = lsu_wb_rd_addr; e.tag = lsu_instr_tag;
        q.push_back(e);
      end
    end
    check("rf_wr_en", 64'(rf_wr_en), 64'(m_en));
    check("rf_wr_addr", 64'(rf_wr_addr), 64'(m_addr));
    check("rf_wr_data", 64'(rf_wr_data), 64'(m_data));
    check("retire_tag", 64'(retire_tag), 64'(m_tag));
    check("retire_src", 64'(retire_src), 64'(m_src));
    check("fifo_count", 64'(fifo_count), 64'(q.size()));
    check("retire_count", 64'(retire_count), 64'(m_writes % (1 << CNTW)));
    if (m_en)
      $display("t=%0t retire src=%0d r%0d=%08h tag=%08h fifo=%0d cnt=%0d",
               $time, m_src, m_addr, m_data, m_tag, q.size(), m_writes % (1 << CNTW));
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) cycle();
    rst = 0;
  endtask

  initial begin
    m_en = 0; m_addr = '0; m_data = '0; m_tag = '0; m_src = 0; m_writes = 0; last_accept = 0;
    rst = 1;
    set_alu(0, '0, '0, '0);
    set_lsu(0, '0, '0, '0);
    @(posedge clk);
    do_reset(2);

    // ALU only
    cycle();
    set_alu(1, 4'd2, 32'h0000_0005, 32'h10); cycle();
    set_alu(1, 4'd3, 32'hFFFF_FFFF, 32'h14); cycle();
    set_alu(0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    check("alu_only_count", 64'(retire_count), 64'(2));

    // LSU only
    set_lsu(1, 4'd1, 32'hDEAD_BEEF, 32'h40); cycle();
    set_lsu(0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();

    // Collision: ALU r4 and LSU r5 in the same cycle
    set_alu(1, 4'd4, 32'd7, 32'h50);
    set_lsu(1, 4'd5, 32'd9, 32'h54); cycle();
    set_alu(0, '0, '0, '0);
    set_lsu(0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();

    // Backpressure: ALU busy, LSU offers 5, ready drops at 4 buffered
    begin
      int k;
      k = 0;
      for (int c = 0; c < 12; c++) begin
        set_alu(1, 4'(c), 32'(c * 3), 32'h100 + 32'(c));
        if (k < 5) set_lsu(1, 4'(8 + k), 32'hA000 + 32'(k), 32'h200 + 32'(k));
        else       set_lsu(0, '0, '0, '0);
        cycle();
        if (last_accept) k++;
      end
      check("bp_fifo_full", 64'(fifo_count), 64'(DEPTH));
      set_alu(0, '0, '0, '0);
      for (int c = 0; c < 10 && k < 5; c++) begin
        set_lsu(1, 4'(8 + k), 32'hA000 + 32'(k), 32'h200 + 32'(k));
        cycle();
        if (last_accept) k++;
      end
      check("bp_all_accepted", 64'(k), 64'(5));
      set_lsu(0, '0, '0, '0);
      for (int c = 0; c < 8; c++) cycle();
    end

    // Reset with 3 buffered entries
    set_alu(1, 4'd6, 32'h66, 32'h300);
    for (int i = 0; i < 3; i++) begin
      set_lsu(1, 4'd7, 32'h700 + 32'(i), 32'h310 + 32'(i));
      cycle();
    end
    set_lsu(0, '0, '0, '0);
    cycle();
    check("pre_reset_fifo", 64'(fifo_count), 64'(3));
    set_alu(0, '0, '0, '0);
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle();

    // Counter wrap with 4-bit counter: 17 back-to-back ALU writes
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      set_alu(1, 4'(i), 32'(i), 32'h400 + 32'(i));
      cycle();
    end
    set_alu(0, '0, '0, '0);
    cycle();
    check("wrap_count", 64'(retire_count), 64'(1));

    // Randomized traffic with varying ALU load and rare resets
    for (int ph = 0; ph < 4; ph++) begin
      int alu_pct;
      alu_pct = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 90 : 70;
      for (int c = 0; c < 400; c++) begin
        set_alu($urandom_range(0, 99) < alu_pct, 4'($urandom), $urandom, $urandom);
        if (!(lsu_wb_valid && !last_accept)) begin
          if ($urandom_range(0, 99) < 60) set_lsu(1, 4'($urandom), $urandom, $urandom);
          else                            set_lsu(0, '0, '0, '0);
        end
        rst = ($urandom_range(0, 199) == 0);
        cycle();
      end
      rst = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback merge stage directly downstream of the ALU.
- Takes the ALU's registered writeback (fixed one result per cycle, cannot be stalled) and the load/store unit's writeback (valid/ready, variable latency).
- Arbitrates the two onto the single register-file write port, buffering LSU results in a small FIFO.
- Produces a retire trace and a retire counter for the testbench and debug.

Parameters:
- XLEN, 32, datapath width.
- REG_FILE_ADDR_WIDTH, 4, register-file address width.
- LSU_FIFO_DEPTH, 4, LSU result buffer entries; power of two, >= 2.
- CNT_WIDTH, 32, retire counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alu_wb_data  in  XLEN  ALU result
- alu_wb_rd_addr  in  REG_FILE_ADDR_WIDTH  ALU destination
- alu_wb_rd_wr_en  in  1  ALU result valid this cycle
- alu_instr_tag  in  XLEN  PC/tag of ALU instruction
- lsu_wb_valid  in  1  LSU result offered
- lsu_wb_ready  out  1  arbiter accepts LSU result
- lsu_wb_data  in  XLEN  LSU load data
- lsu_wb_rd_addr  in  REG_FILE_ADDR_WIDTH  LSU destination
- lsu_instr_tag  in  XLEN  PC/tag of LSU instruction
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  REG_FILE_ADDR_WIDTH  write address
- rf_wr_data  out  XLEN  write data
- retire_tag  out  XLEN  tag of instruction written this cycle
- retire_src  out  1  0 = ALU, 1 = LSU
- fifo_count  out  $clog2(LSU_FIFO_DEPTH)+1  LSU entries buffered
- retire_count  out  CNT_WIDTH  total register writes since reset

Behaviour:
- Reset: synchronous active-high. On the first rising edge with rst=1:
  - all outputs go to 0: rf_wr_en, rf_wr_addr, rf_wr_data, retire_tag, retire_src, retire_count, fifo_count.
  - FIFO read and write pointers clear.
  - Buffered entries are discarded, including any mid-operation contents.
  - lsu_wb_ready is 0 while rst=1.
- LSU handshake:
  - lsu_wb_ready = ~rst & (fifo_count < LSU_FIFO_DEPTH). Combinational from registered count only; no dependence on lsu_wb_valid.
  - Transfer happens when lsu_wb_valid & lsu_wb_ready. The entry {data, rd_addr, tag} is written at the tail.
  - When full, no enqueue occurs even if a pop happens the same cycle (no full-throughput pass-through).
  - The LSU must hold its data stable while valid & ~ready.
- Arbitration, evaluated each cycle on registered state:
  - If alu_wb_rd_wr_en = 1: select the ALU. ALU has absolute priority because it cannot stall.
  - Else if the FIFO is non-empty: pop the head, select LSU.
  - Else: idle.
  - An entry enqueued in cycle N is visible for pop from cycle N+1. There is no bypass.
- Output register:
  - The selected result is registered. rf_wr_en/addr/data, retire_tag and retire_src are valid the cycle after selection.
  - When idle, rf_wr_en = 0 and the other output fields hold their previous values.
- Latency:
  - ALU input at cycle N -> rf write at N+1.
  - LSU handshake at N -> earliest rf write at N+2.
  - LSU latency is unbounded while the ALU writes back-to-back; the arbiter has no starvation guard.
- FIFO:
  - Circular buffer with pointers of $clog2(LSU_FIFO_DEPTH) bits that wrap modulo depth.
  - fifo_count: +1 on enqueue only, -1 on pop only, unchanged on simultaneous enqueue and pop.
  - Never exceeds LSU_FIFO_DEPTH and never underflows.
- Ordering: the issue stage guarantees no outstanding WAW hazard between in-flight LSU and ALU destinations. The arbiter preserves order only within the LSU stream.
- All destination addresses are written, including r0 (eBPF r0 is a real register).
- retire_count: increments by 1 on every cycle in which rf_wr_en is asserted; wraps modulo 2^CNT_WIDTH with no saturation.

Test Plan:
- ALU only: after reset, ALU writes r2=0x0000_0005 at cycle 3 and r3=0xFFFF_FFFF at cycle 4 -> rf_wr_en high at cycles 4 and 5 with matching addr/data; retire_src=0; retire_count=2.
- LSU only: lsu_wb_valid with r1=0xDEAD_BEEF, tag 0x40, handshake at cycle 5 -> rf write r1=0xDEAD_BEEF at cycle 7; retire_tag=0x40; retire_src=1; fifo_count goes 1 then 0.
- Collision: ALU r4=7 and LSU r5=9 (handshake) in the same cycle N -> r4 written at N+1, r5 written at N+2.
- Backpressure: ALU writes every cycle; LSU offers 5 results -> lsu_wb_ready drops after the 4th accept, with fifo_count=4. When the ALU goes quiet, 4 writes drain in FIFO order, the 5th is accepted, and all 5 tags retire in order.
- Reset mid-operation: fifo_count=3, rst asserted for 1 cycle -> fifo_count=0, rf_wr_en=0, retire_count=0. None of the 3 entries is ever written.
- Counter wrap: CNT_WIDTH=4, 17 ALU writes -> retire_count reads 0xF after the 15th write, 0x0 after the 16th, 0x1 after the 17th.
